// File: rtl/barcode_check_pkg.sv
// Shared PS/2 set-2 digit scan codes, EAN-13 widths and the checker state encoding.
// Imported by the scan-code LUT and the barcode checker.
package barcode_check_pkg;

    localparam int CHARS    = 13;
    localparam int CODE_W   = CHARS * 8;
    localparam int DIGITS_W = CHARS * 4;
    localparam int ACC_W    = 8;
    localparam int IDX_W    = 4;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHARS - 1);

    localparam logic [7:0] SC_0 = 8'h45;
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E;
    localparam logic [7:0] SC_6 = 8'h36;
    localparam logic [7:0] SC_7 = 8'h3D;
    localparam logic [7:0] SC_8 = 8'h3E;
    localparam logic [7:0] SC_9 = 8'h46;

    localparam logic [3:0] BAD_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // EAN-13 check digit from the weighted sum of the first twelve digits.
    function automatic logic [3:0] expected_check(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] rem;
        rem = acc % ACC_W'(10);
        if (rem == '0)
            return 4'd0;
        return 4'(ACC_W'(10) - rem);
    endfunction

endpackage

// File: rtl/ps2_digit_lut.sv
// Combinational PS/2 set-2 make code to BCD digit decoder.
// Anything that is not a digit key returns 4'hF with valid low.
module ps2_digit_lut
    import barcode_check_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = BAD_DIGIT;
        valid = 1'b1;
        case (code)
            SC_0:    digit = 4'd0;
            SC_1:    digit = 4'd1;
            SC_2:    digit = 4'd2;
            SC_3:    digit = 4'd3;
            SC_4:    digit = 4'd4;
            SC_5:    digit = 4'd5;
            SC_6:    digit = 4'd6;
            SC_7:    digit = 4'd7;
            SC_8:    digit = 4'd8;
            SC_9:    digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/barcode_check.sv
// EAN-13 barcode checker: snapshots 13 PS/2 make codes, decodes one per cycle,
// and reports check-digit validity with a fixed 14-cycle latency.
module barcode_check
    import barcode_check_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CODE_W-1:0]   ps2_register,
    output logic                busy,
    output logic                done,
    output logic                code_ok,
    output logic                bad_char,
    output logic [DIGITS_W-1:0] digits
);

    state_t              state;
    logic [CODE_W-1:0]   snap;
    logic [DIGITS_W-1:0] shadow;
    logic [ACC_W-1:0]    acc;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          check;
    logic                bad;

    logic [3:0]          lut_digit;
    logic                lut_valid;
    logic [ACC_W-1:0]    d8;
    logic [ACC_W-1:0]    addend;

    // The snapshot shifts left each scan cycle, so the current character is always on top.
    ps2_digit_lut u_lut (
        .code  (snap[CODE_W-1 -: 8]),
        .digit (lut_digit),
        .valid (lut_valid)
    );

    always_comb begin
        d8     = {{(ACC_W-4){1'b0}}, lut_digit};
        addend = '0;
        if (lut_valid)
            addend = idx[0] ? (d8 + (d8 << 1)) : d8;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            snap     <= '0;
            shadow   <= '0;
            acc      <= '0;
            idx      <= '0;
            check    <= '0;
            bad      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            code_ok  <= 1'b0;
            bad_char <= 1'b0;
            digits   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        snap  <= ps2_register;
                        acc   <= '0;
                        bad   <= 1'b0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    shadow <= {shadow[DIGITS_W-5:0], lut_digit};
                    snap   <= snap << 8;
                    idx    <= idx + IDX_W'(1);
                    if (!lut_valid)
                        bad <= 1'b1;
                    if (idx == IDX_LAST) begin
                        check <= lut_digit;
                        state <= ST_CHECK;
                    end else begin
                        acc <= acc + addend;
                    end
                end
                ST_CHECK: begin
                    digits   <= shadow;
                    code_ok  <= !bad && (expected_check(acc) == check);
                    bad_char <= bad;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
